key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2, the number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the stable-input clock cycles required to accept a change (legal range 2..2^20).
REQ-003 SHALL have port clk  input  1  system clock; all state is updated on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_n_raw  input  NUM_KEYS  raw push-button pins, active-low, asynchronous to clk, bouncing.
REQ-006 SHALL have port key_level  output  NUM_KEYS  debounced key state, active-high (1 = pressed); this drives the downstream PIO in_port.
REQ-007 SHALL have port press_pulse  output  NUM_KEYS  one-cycle strobe per key on an accepted press.
REQ-008 SHALL have port release_pulse  output  NUM_KEYS  one-cycle strobe per key on an accepted release.

Function
REQ-009 SHALL pass each key_n_raw bit through a two-flop synchronizer; the sampled pressed value s[i] is the inverse of the second flop.
REQ-010 SHALL implement one independent FSM and one counter per key; no shared state between keys.
REQ-011 SHALL use FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED: if s[i]=1 -> PRESS_WAIT with counter cleared to 0; otherwise remain.
REQ-013 PRESS_WAIT: if s[i]=0 -> RELEASED and clear counter (bounce rejected); else if counter = DEBOUNCE_CYCLES-1 -> PRESSED; else counter increments by 1.
REQ-014 PRESSED: if s[i]=0 -> RELEASE_WAIT with counter cleared to 0; otherwise remain.
REQ-015 RELEASE_WAIT: if s[i]=1 -> PRESSED and clear counter; else if counter = DEBOUNCE_CYCLES-1 -> RELEASED; else counter increments by 1.
REQ-016 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter never wraps, as it is cleared or stops at DEBOUNCE_CYCLES-1.
REQ-017 key_level[i] SHALL be a registered output: 1 in PRESSED and RELEASE_WAIT, 0 in RELEASED and PRESS_WAIT.
REQ-018 press_pulse[i] SHALL be high for exactly the one cycle in which key_level[i] first reads 1 after the PRESS_WAIT->PRESSED transition.
REQ-019 release_pulse[i] SHALL be high for exactly the one cycle in which key_level[i] first reads 0 after the RELEASE_WAIT->RELEASED transition.
REQ-020 Latency: for a stable press, key_level[i] SHALL rise on the (DEBOUNCE_CYCLES+3)th rising edge, counting the edge that first samples key_n_raw[i] low as edge 1; release latency SHALL be identical.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES+1 synchronized cycles SHALL produce no change on key_level and no pulse.
REQ-022 Simultaneous presses or releases on several keys SHALL be handled independently, and may assert pulses on multiple bits in the same cycle.
REQ-023 press_pulse[i] and release_pulse[i] SHALL never be high in the same cycle.

Reset
REQ-024 On reset_n low, asynchronously: synchronizer flops SHALL be set to 1 (released), all FSMs to RELEASED, all counters to 0, and key_level, press_pulse, release_pulse to 0.
REQ-025 Reset asserted mid-debounce or mid-press SHALL abort the operation and emit no pulse.
REQ-026 After reset release, a key held low SHALL be accepted as a fresh press with full REQ-020 latency.

Verification (DEBOUNCE_CYCLES=4, NUM_KEYS=2)
REQ-027 key_n_raw=2'b11 -> 2'b10 held -> key_level=2'b01 on edge 7; press_pulse=2'b01 for exactly that one cycle; release_pulse stays 0.
REQ-028 key_n_raw[0] low for 3 cycles then high -> key_level and both pulses remain 0 throughout.
REQ-029 key_n_raw[0] toggles every cycle for 20 cycles then stays low -> exactly one press_pulse, 7 edges after the final stable sample.
REQ-030 Both keys pressed on the same edge and released 20 cycles later -> press_pulse=2'b11 for one cycle, then release_pulse=2'b11 for one cycle; key_level=2'b11 between them.
REQ-031 Key held low and reset_n pulsed low for 2 cycles mid-PRESSED -> all outputs 0 during reset, no release_pulse, then press re-accepted 7 edges after reset deassertion.
REQ-032 Key pressed, then a 2-cycle high glitch while pressed -> key_level stays 1 and no release_pulse is generated.

Source files
------------

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key push-button debouncer with press/release strobes
// Two-flop synchronizer feeding one four-state FSM and stability counter per key.
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] s;

  // Synchronizer idles at 1 so a reset looks like all keys released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_n_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign s = ~sync_q2;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= RELEASED;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          RELEASED: begin
            if (s[i]) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s[i]) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              // Level and strobe update on the same edge as the state change.
              state   <= PRESSED;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PRESSED: begin
            if (!s[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (s[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state   <= RELEASED;
            cnt     <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce (4-cycle debounce, 2 keys)
// Expected strobes are queued with their cycle when stimulus is applied.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] key_n_raw = 2'b11;
  logic [1:0] key_level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  typedef struct {
    int         cyc;
    bit         rel;
    logic [1:0] mask;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  edge_cnt = 0;
  int  vectors = 0;
  int  miscompares = 0;

  key_debounce #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_n_raw    (key_n_raw),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Every strobe seen must match the head of the expectation queue.
  always @(negedge clk) begin
    vectors++;
    if ((press_pulse & release_pulse) !== 2'b00) begin
      miscompares++;
      $display("FAIL pulse_overlap press %b release %b required no common bit", press_pulse, release_pulse);
    end
    if (press_pulse !== 2'b00) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_press got %b at cycle %0d required none", press_pulse, edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rel || mon_e.mask !== press_pulse || mon_e.cyc != edge_cnt) begin
          miscompares++;
          $display("FAIL press_event got press %b cycle %0d required rel=%0d mask %b cycle %0d",
                   press_pulse, edge_cnt, mon_e.rel, mon_e.mask, mon_e.cyc);
        end
      end
    end
    if (release_pulse !== 2'b00) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_release got %b at cycle %0d required none", release_pulse, edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.rel || mon_e.mask !== release_pulse || mon_e.cyc != edge_cnt) begin
          miscompares++;
          $display("FAIL release_event got release %b cycle %0d required rel=%0d mask %b cycle %0d",
                   release_pulse, edge_cnt, mon_e.rel, mon_e.mask, mon_e.cyc);
        end
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({key_level, press_pulse, release_pulse} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_outputs got %b required 000000", {key_level, press_pulse, release_pulse});
      end
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) @(negedge clk);
  endtask

  task automatic test_single_press();
    int n0, n1;
    @(negedge clk);
    key_n_raw = 2'b10;
    n0 = edge_cnt;
    exp_q.push_back('{cyc: n0 + 7, rel: 1'b0, mask: 2'b01});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (key_level !== ((edge_cnt >= n0 + 7) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL single_press_level got %b at cycle %0d (press at %0d)", key_level, edge_cnt, n0);
      end
    end
    key_n_raw = 2'b11;
    n1 = edge_cnt;
    exp_q.push_back('{cyc: n1 + 7, rel: 1'b1, mask: 2'b01});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (key_level !== ((edge_cnt >= n1 + 7) ? 2'b00 : 2'b01)) begin
        miscompares++;
        $display("FAIL single_release_level got %b at cycle %0d (release at %0d)", key_level, edge_cnt, n1);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_press_missing got %0d pending events required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_short_glitch();
    @(negedge clk);
    key_n_raw = 2'b10;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) key_n_raw = 2'b11;
      vectors++;
      if (key_level !== 2'b00) begin
        miscompares++;
        $display("FAIL short_glitch_level got %b required 00", key_level);
      end
    end
  endtask

  task automatic test_bounce();
    int n0, n1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_n_raw[0] = ~key_n_raw[0];
      vectors++;
      if (key_level !== 2'b00) begin
        miscompares++;
        $display("FAIL bounce_level got %b required 00", key_level);
      end
    end
    @(negedge clk);
    key_n_raw = 2'b10;
    n0 = edge_cnt;
    exp_q.push_back('{cyc: n0 + 7, rel: 1'b0, mask: 2'b01});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (key_level !== ((edge_cnt >= n0 + 7) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL bounce_settle_level got %b at cycle %0d (settle at %0d)", key_level, edge_cnt, n0);
      end
    end
    key_n_raw = 2'b11;
    n1 = edge_cnt;
    exp_q.push_back('{cyc: n1 + 7, rel: 1'b1, mask: 2'b01});
    for (int c = 0; c < 12; c++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bounce_missing got %0d pending events required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    @(negedge clk);
    key_n_raw = 2'b00;
    n0 = edge_cnt;
    exp_q.push_back('{cyc: n0 + 7, rel: 1'b0, mask: 2'b11});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (key_level !== ((edge_cnt >= n0 + 7) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL both_press_level got %b at cycle %0d (press at %0d)", key_level, edge_cnt, n0);
      end
    end
    key_n_raw = 2'b11;
    n1 = edge_cnt;
    exp_q.push_back('{cyc: n1 + 7, rel: 1'b1, mask: 2'b11});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (key_level !== ((edge_cnt >= n1 + 7) ? 2'b00 : 2'b11)) begin
        miscompares++;
        $display("FAIL both_release_level got %b at cycle %0d (release at %0d)", key_level, edge_cnt, n1);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL both_keys_missing got %0d pending events required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_press();
    int n0, r0, n1;
    @(negedge clk);
    key_n_raw = 2'b10;
    n0 = edge_cnt;
    exp_q.push_back('{cyc: n0 + 7, rel: 1'b0, mask: 2'b01});
    for (int c = 0; c < 10; c++) @(negedge clk);
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({key_level, press_pulse, release_pulse} !== 6'b0) begin
        miscompares++;
        $display("FAIL mid_reset_outputs got %b required 000000", {key_level, press_pulse, release_pulse});
      end
    end
    reset_n = 1'b1;
    r0 = edge_cnt;
    exp_q.push_back('{cyc: r0 + 7, rel: 1'b0, mask: 2'b01});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (key_level !== ((edge_cnt >= r0 + 7) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL reaccept_level got %b at cycle %0d (reset release at %0d)", key_level, edge_cnt, r0);
      end
    end
    key_n_raw = 2'b11;
    n1 = edge_cnt;
    exp_q.push_back('{cyc: n1 + 7, rel: 1'b1, mask: 2'b01});
    for (int c = 0; c < 12; c++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_missing got %0d pending events required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_press_glitch();
    int n0, n1;
    @(negedge clk);
    key_n_raw = 2'b10;
    n0 = edge_cnt;
    exp_q.push_back('{cyc: n0 + 7, rel: 1'b0, mask: 2'b01});
    for (int c = 0; c < 10; c++) @(negedge clk);
    key_n_raw = 2'b11;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 1) key_n_raw = 2'b10;
      vectors++;
      if (key_level !== 2'b01) begin
        miscompares++;
        $display("FAIL held_glitch_level got %b required 01", key_level);
      end
    end
    key_n_raw = 2'b11;
    n1 = edge_cnt;
    exp_q.push_back('{cyc: n1 + 7, rel: 1'b1, mask: 2'b01});
    for (int c = 0; c < 12; c++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL press_glitch_missing got %0d pending events required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_short_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_mid_press();
    test_press_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
